muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the CPU datapath, directly downstream of the register-file read ports. It takes the two source operands read for a MULT/MULTU/DIV/DIVU instruction, computes the 64-bit result over 33 cycles, and holds it in the architectural HI/LO registers. It raises `busy` so the pipeline can stall, and it serves MTHI/MTLO writes. The CPU reads `hi`/`lo` for MFHI/MFLO and routes them to the register-file write port.

---
 rtl/muldiv_unit.sv | 123 ++++++++++++
 tb/tb_muldiv_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit holding the HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed in the last cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // state | meaning
    // IDLE  | waiting for start, serves MTHI/MTLO
    // CALC  | 32 iterations of shift-add or restoring divide
    // FIX   | sign correction / div-by-zero handling, write HI/LO
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] mb;
    logic [31:0] raw_a;
    logic        sa, sb, dz;
    logic [63:0] p;

    logic        is_div, is_sgn;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [63:0] p_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign busy   = (state != IDLE);
    assign is_div = op_q[1];
    assign is_sgn = op_q[0];

    // p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, mb} : 33'd0);
        rem_sh  = {p[63:32], p[31]};
        rem_ge  = (rem_sh >= {1'b0, mb});
        p_next  = p;
        if (is_div) begin
            if (rem_ge) p_next = {rem_sh[31:0] - mb, p[30:0], 1'b1};
            else        p_next = {rem_sh[31:0], p[30:0], 1'b0};
        end else begin
            p_next = {mul_sum, p[31:1]};
        end
    end

    always_comb begin
        prod_fix = (is_sgn && (sa ^ sb)) ? (~p + 64'd1) : p;
        quo_fix  = (is_sgn && (sa ^ sb)) ? (~p[31:0] + 32'd1) : p[31:0];
        rem_fix  = (is_sgn && sa) ? (~p[63:32] + 32'd1) : p[63:32];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_q  <= 2'b00;
            mb    <= 32'd0;
            raw_a <= 32'd0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz    <= 1'b0;
            p     <= 64'd0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIX: begin
                    if (state == FIX) begin
                        done <= 1'b1;
                        if (is_div && dz) begin
                            hi <= raw_a;
                            lo <= 32'hFFFF_FFFF;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                    // FIX returns to IDLE on this edge, so a start here is accepted back-to-back
                    if (start) begin
                        op_q  <= op;
                        sa    <= op[0] & a[31];
                        sb    <= op[0] & b[31];
                        p     <= {32'd0, (op[0] && a[31]) ? (~a + 32'd1) : a};
                        mb    <= (op[0] && b[31]) ? (~b + 32'd1) : b;
                        raw_a <= a;
                        dz    <= op[1] && (b == 32'd0);
                        cnt   <= 5'd0;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                        if (state == IDLE) begin
                            if (mthi) hi <= wdata;
                            if (mtlo) lo <= wdata;
                        end
                    end
                end
                CALC: begin
                    p   <= p_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency, done pulse, MTHI/MTLO and clr abort.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        clr, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op; inject_cyc>0 asserts start+mthi (wdata=1) during that busy cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ehi, input logic [31:0] elo, input int inject_cyc);
        int cycles;
        int dones;
        logic [31:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        op = o; a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        dones = 0;
        chk({tag, "_busy_e0"}, busy, 1'b1);
        while (busy && cycles < 40) begin
            if (cycles + 1 == inject_cyc) begin
                start = 1'b1; mthi = 1'b1; wdata = 32'd1; op = 2'b00; a = 32'd9; b = 32'd9;
            end
            tick();
            start = 1'b0; mthi = 1'b0;
            cycles++;
            if (done) dones++;
            if (cycles == 16) chk({tag, "_hold"}, {hi, lo}, {hi0, lo0});
        end
        chk({tag, "_lat"}, cycles, 33);
        chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
        chk({tag, "_done"}, {dones[7:0], done}, {8'd1, 1'b1});
        tick();
        chk({tag, "_done_off"}, done, 1'b0);
    endtask

    initial begin
        int stray;
        clr = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
        tick(); tick();
        clr = 1'b0;
        chk("rst_state", {busy, done, hi, lo}, 66'd0);

        run_op("ignore", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 5);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_negb", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
        run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("div_wrap", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        run_op("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        run_op("div_zero", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);

        mthi = 1'b1; wdata = 32'hAAAA_0000;
        tick();
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000_BBBB;
        chk("mthi", hi, 32'hAAAA_0000);
        tick();
        mtlo = 1'b0;
        chk("mtlo", {hi, lo}, {32'hAAAA_0000, 32'h0000_BBBB});
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555_1234;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_both", {hi, lo}, {32'h5555_1234, 32'h5555_1234});

        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_abort", {busy, done, hi, lo}, 66'd0);
        stray = 0;
        repeat (30) begin
            tick();
            if (done || busy) stray++;
        end
        chk("clr_no_done", stray, 0);
        run_op("after_clr", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
